serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/adder.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and constants for the bit-serial adder
//                controller: FSM state encoding and default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting for operands, shifting bits, holding result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : 1-bit full adder, combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of three single-bit inputs
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder controller. Captures a, b and cin on a
//                valid/ready handshake, adds one bit per cycle LSB first
//                through a single full adder, then presents {cout,sum} with
//                a valid/ready handshake. The published result holds until
//                the next operation completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter must be able to represent WIDTH-1 for every legal WIDTH
    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_bit_sum;
    logic               w_bit_cout;
    logic               w_last;
    logic               w_accept;

    // Single full adder shared across all bit positions
    adder u_adder (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_bit_sum),
        .cout (w_bit_cout)
    );

    // New sum bit enters at the MSB so the LSB-first result ends up aligned
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_bit_sum;
        end else begin : g_res_wn
            assign w_res_nxt = {w_bit_sum, r_res[WIDTH-1:1]};
        end
    endgenerate

    assign w_last   = (r_cnt == c_LAST);
    assign w_accept = (r_state == IDLE) && in_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_bit_cout;
            r_cnt   <= r_cnt + 1'b1;
            // Publish only when the final bit is done so sum/cout never
            // show a partial result
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_bit_cout;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl (WIDTH=8).
//                Expected results come from plain integer addition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [W:0]   last_res;
    bit           have_last;

    serial_adder_ctrl #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete operation starting at a negedge in IDLE. After the
    // DONE->IDLE edge the next operands (and optionally in_valid) are
    // already on the inputs, so a held request can be observed.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input int stall, input bit pend,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
        logic [W:0] exp;
        bit         early;
        bit         held;
        bit         stable;
        exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        chk("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        // Scramble inputs: they must not influence the running sum
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        early = 0; held = 1;
        for (int i = 0; i < W; i++) begin
            if (out_valid || in_ready || !busy) early = 1;
            if (have_last && ({cout, sum} !== last_res)) held = 0;
            @(negedge clk);
        end
        chk("run_flags", early, 0);
        if (have_last) chk("prev_result_held", held, 1);
        chk("out_valid_latency", out_valid, 1);
        chk("sum", sum, exp[W-1:0]);
        chk("cout", cout, exp[W]);
        // A request during DONE must be ignored
        in_valid = pend; a = na; b = nb; cin = nc;
        stable = 1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid || in_ready || ({cout, sum} !== exp)) stable = 0;
        end
        if (stall > 0) chk("stall_stable", stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_done", busy, 0);
        chk("valid_dropped", out_valid, 0);
        last_res  = exp;
        have_last = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ca, cb, xa, xb;
        logic         cc, xc;
        bit           p;

        // Reset with a request pending: reset must win
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'h5A; b = 8'hA5; cin = 1'b1;
        have_last = 0; last_res = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Directed cases
        run_op(8'h12, 8'h34, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 5, 0, 8'h00, 8'h00, 1'b0);

        // Request held across the DONE->IDLE edge, accepted one edge later
        run_op(8'h80, 8'h80, 1'b0, 2, 1, 8'h3C, 8'h0F, 1'b1);
        chk("held_req_not_taken", in_ready, 1);
        run_op(8'h3C, 8'h0F, 1'b1, 0, 0, 8'h00, 8'h00, 1'b0);

        // Reset in the 4th RUN cycle aborts the operation
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sum", sum, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        last_res = '0;
        run_op(8'h01, 8'h01, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0);

        // Randomized operations with stalls and held requests
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        for (int n = 0; n < 1500; n++) begin
            xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
            p  = 1'($urandom);
            run_op(ca, cb, cc, int'($urandom_range(0, 3)), p, xa, xb, xc);
            if (p) chk("rand_held_req", in_ready, 1);
            ca = xa; cb = xb; cc = xc;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
